// File: rtl/four_bank_mem_responder_pkg.sv
// Shared constants for the four-bank main-memory responder.
// Bank geometry, counter width and default timing.
package four_bank_mem_responder_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_LSB     = 1;
  localparam int BANK_MSB     = 2;
  localparam int CNT_W        = 4;
  localparam int DEF_BANK_CYC = 4;
  localparam int DEF_RD_LAT   = 2;

  typedef logic [BANK_MSB-BANK_LSB:0] bank_t;

endpackage

// File: rtl/four_bank_mem_responder_bank_timer.sv
// Per-bank occupancy timer: loads on accept, counts down,
// saturates at zero; busy while the count is nonzero.
module bank_timer
  import four_bank_mem_responder_pkg::*;
#(
  parameter int BANK_CYC = DEF_BANK_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(BANK_CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = |cnt;

endmodule

// File: rtl/four_bank_mem_responder.sv
// Four-bank interleaved word memory serving cache fills:
// per-bank occupancy, combinational stall, 2-cycle read return.
module four_bank_mem_responder
  import four_bank_mem_responder_pkg::*;
#(
  parameter int BANK_CYC  = DEF_BANK_CYC,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  input  logic                 rd,
  input  logic                 wr,
  output logic [15:0]          data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  if (BANK_CYC < 2 || BANK_CYC > 15) begin : g_bad_cyc
    $error("BANK_CYC out of range");
  end
  if (RD_LAT != 2) begin : g_bad_lat
    $error("RD_LAT must be 2");
  end
  if (MEM_WORDS < 4 || MEM_WORDS > 32768) begin : g_bad_words
    $error("MEM_WORDS out of range");
  end

  logic                 req;
  logic                 illegal;
  logic                 accept;
  logic                 bank_busy;
  bank_t                bank;
  logic [IDX_W-1:0]     idx;
  logic [NUM_BANKS-1:0] load;

  assign req       = rd | wr;
  assign illegal   = req & ((rd & wr) | addr[0]);
  assign bank      = addr[BANK_MSB:BANK_LSB];
  assign bank_busy = busy[bank];
  assign accept    = req & ~illegal & ~bank_busy;
  assign stall     = req & ~illegal & bank_busy;
  // truncation gives the modulo-MEM_WORDS wrap
  assign idx       = IDX_W'(addr[15:1]);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign load[b] = accept & (bank == bank_t'(b));

    bank_timer #(
      .BANK_CYC(BANK_CYC)
    ) u_timer (
      .clk (clk),
      .rst (rst),
      .load(load[b]),
      .busy(busy[b])
    );
  end

  logic [15:0] mem [MEM_WORDS];
  logic [15:0] s1_data;
  logic        s1_valid;

  // storage survives reset; reset only blocks new accesses
  always_ff @(posedge clk) begin
    if (rst && accept && wr) begin
      mem[idx] <= data_in;
    end
    if (rst && accept && rd) begin
      s1_data <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      rd_valid <= 1'b0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      s1_valid <= accept & rd;
      rd_valid <= s1_valid;
      data_out <= s1_valid ? s1_data : '0;
      err      <= illegal;
    end
  end

endmodule
